// File: rtl/arb_stream_mux_if.sv
// Bundle of the stream-mux signals shared with the environment.
//   s_valid/s_ready/s_data/s_last : NUM_REQS input packet streams
//   req/gnt                        : request lines to, and one-hot grant from, the arbiter
//   m_valid/m_ready/m_data/m_last/m_src : registered output stream
//   err                            : sticky protocol error flag
// Modport slave is the mux itself; modport master is whatever drives it.
interface arb_stream_mux_if #(
  parameter int unsigned NUM_REQS = 4,
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned SRC_W    = (NUM_REQS > 1) ? $clog2(NUM_REQS) : 1
);
  logic [NUM_REQS-1:0]        s_valid;
  logic [NUM_REQS-1:0]        s_ready;
  logic [NUM_REQS*DATA_W-1:0] s_data;
  logic [NUM_REQS-1:0]        s_last;
  logic [NUM_REQS-1:0]        req;
  logic [NUM_REQS-1:0]        gnt;
  logic                       m_valid;
  logic                       m_ready;
  logic [DATA_W-1:0]          m_data;
  logic                       m_last;
  logic [SRC_W-1:0]           m_src;
  logic                       err;

  modport master (
    output s_valid, s_data, s_last, gnt, m_ready,
    input  s_ready, req, m_valid, m_data, m_last, m_src, err
  );

  modport slave (
    input  s_valid, s_data, s_last, gnt, m_ready,
    output s_ready, req, m_valid, m_data, m_last, m_src, err
  );
endinterface

// File: rtl/arb_stream_mux.sv
// Packet-stream front/back end for a shared-resource arbiter. Each input channel raises req
// while it owns a packet, the one-hot grant selects which channel may push beats into a
// single registered output stage, and req drops after the last beat so the arbiter rotates.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : arb_stream_mux_if.slave (input streams, req/gnt, output stream, err)
module arb_stream_mux #(
  parameter int unsigned NUM_REQS = 4,
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned SRC_W    = (NUM_REQS > 1) ? $clog2(NUM_REQS) : 1
) (
  input logic             clk,
  input logic             rst_n,
  arb_stream_mux_if.slave bus
);

  typedef enum logic [1:0] {StIdle, StReq, StXfer, StRelease} state_e;

  state_e state_q [NUM_REQS];
  state_e state_d [NUM_REQS];

  logic [NUM_REQS-1:0] active;
  logic [NUM_REQS-1:0] idle;
  logic [NUM_REQS-1:0] ready;
  logic [NUM_REQS-1:0] accept;

  logic              gnt_ok;
  logic              space;
  logic              acc_any;
  logic [SRC_W-1:0]  acc_idx;
  logic [DATA_W-1:0] acc_data;
  logic              acc_last;

  logic              m_valid_q;
  logic [DATA_W-1:0] m_data_q;
  logic              m_last_q;
  logic [SRC_W-1:0]  m_src_q;
  logic              err_q;
  logic              err_d;

  assign gnt_ok = $onehot(bus.gnt);
  assign space  = !m_valid_q || bus.m_ready;

  // A valid grant selects at most one channel, so at most one accept bit is set.
  always_comb begin
    active   = '0;
    idle     = '0;
    ready    = '0;
    accept   = '0;
    acc_any  = 1'b0;
    acc_idx  = '0;
    acc_data = '0;
    acc_last = 1'b0;
    for (int unsigned i = 0; i < NUM_REQS; i++) begin
      active[i] = (state_q[i] == StReq) || (state_q[i] == StXfer);
      idle[i]   = (state_q[i] == StIdle);
      ready[i]  = active[i] && bus.gnt[i] && gnt_ok && space;
      accept[i] = bus.s_valid[i] && ready[i];
      if (accept[i]) begin
        acc_any  = 1'b1;
        acc_idx  = SRC_W'(i);
        acc_data = bus.s_data[i*DATA_W +: DATA_W];
        acc_last = bus.s_last[i];
      end
    end
  end

  // RELEASE holds req low until the arbiter has withdrawn the grant, which also
  // prevents a last beat from chaining straight into the next packet.
  always_comb begin
    for (int unsigned i = 0; i < NUM_REQS; i++) begin
      state_d[i] = state_q[i];
      unique case (state_q[i])
        StIdle:    if (bus.s_valid[i]) state_d[i] = StReq;
        StReq:     if (accept[i]) state_d[i] = bus.s_last[i] ? StRelease : StXfer;
        StXfer:    if (accept[i] && bus.s_last[i]) state_d[i] = StRelease;
        StRelease: if (!bus.gnt[i]) state_d[i] = StIdle;
        default:   state_d[i] = StIdle;
      endcase
    end
  end

  assign err_d = err_q || !$onehot0(bus.gnt) || ((bus.gnt & idle) != '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NUM_REQS; i++) state_q[i] <= StIdle;
      err_q <= 1'b0;
    end else begin
      for (int unsigned i = 0; i < NUM_REQS; i++) state_q[i] <= state_d[i];
      err_q <= err_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_valid_q <= 1'b0;
      m_data_q  <= '0;
      m_last_q  <= 1'b0;
      m_src_q   <= '0;
    end else if (acc_any) begin
      m_valid_q <= 1'b1;
      m_data_q  <= acc_data;
      m_last_q  <= acc_last;
      m_src_q   <= acc_idx;
    end else if (bus.m_ready) begin
      m_valid_q <= 1'b0;
    end
  end

  assign bus.req     = active;
  assign bus.s_ready = ready;
  assign bus.m_valid = m_valid_q;
  assign bus.m_data  = m_data_q;
  assign bus.m_last  = m_last_q;
  assign bus.m_src   = m_src_q;
  assign bus.err     = err_q;

endmodule
